// File: rtl/ipv4_rx_parser.sv
// ipv4_rx_parser: decodes one IPv4 datagram presented as a 32-bit big-endian
// word stream. Extracts header fields, verifies checksum and length, filters
// on destination address, and forwards option and payload words.
module ipv4_rx_parser #(
  parameter bit          CHECK_CHKSUM = 1'b1,
  parameter bit          DEST_FILTER  = 1'b0,
  parameter logic [31:0] LOCAL_IP     = 32'h980E5E4B,
  parameter int unsigned MAX_IHL      = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic        valid,
  input  logic        start,
  output logic [3:0]  version,
  output logic [3:0]  IHL,
  output logic [7:0]  type_of_ser,
  output logic [7:0]  time_to_live,
  output logic [7:0]  protocol,
  output logic [15:0] total_length,
  output logic [15:0] identification,
  output logic [15:0] head_chks16,
  output logic [2:0]  flag,
  output logic [12:0] frag_offset,
  output logic [31:0] src_ip,
  output logic [31:0] dest_ip,
  output logic [31:0] opt_data,
  output logic        opt_wr,
  output logic [15:0] len_out,
  output logic [31:0] data_out,
  output logic        wr_en,
  output logic [3:0]  keep,
  output logic        ok,
  output logic        fin,
  output logic [4:0]  err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    OPT     = 3'd2,
    PAYLOAD = 3'd3,
    DROP    = 3'd4
  } state_t;

  state_t      state_r;
  logic [2:0]  idx_r;
  logic [15:0] cnt_r;
  logic [16:0] acc_r;
  logic [4:0]  pend_err_r;
  logic        pend_ok_r;

  logic [16:0] acc_w0_s;
  logic [16:0] acc_nx_s;
  logic [3:0]  w0_ihl_s;
  logic        w0_bad_s;
  logic [13:0] w0_words_s;
  logic [31:0] dst_s;
  logic [15:0] hdr_bytes_s;
  logic [15:0] plen_s;
  logic [15:0] pwords_s;
  logic        chk_bad_s;
  logic        len_bad_s;
  logic        dm_s;
  logic        enf_s;
  logic [4:0]  err_v_s;
  logic        last_hdr_s;

  // One's-complement add of both 16-bit halves of a word, carry folded back in.
  // The result never carries out, so bit 16 of the return value stays 0.
  function automatic logic [16:0] csum_add(input logic [16:0] acc, input logic [31:0] w);
    logic [16:0] t;
    t = {1'b0, acc[15:0]} + {1'b0, w[31:16]};
    t = {1'b0, t[15:0]} + {16'h0000, t[16]};
    t = {1'b0, t[15:0]} + {1'b0, w[15:0]};
    t = {1'b0, t[15:0]} + {16'h0000, t[16]};
    return t;
  endfunction

  // Byte-valid mask for the final payload word given len_out mod 4.
  function automatic logic [3:0] last_keep(input logic [1:0] m);
    logic [3:0] k;
    case (m)
      2'd1:    k = 4'b1000;
      2'd2:    k = 4'b1100;
      2'd3:    k = 4'b1110;
      default: k = 4'b1111;
    endcase
    return k;
  endfunction

  assign acc_w0_s    = csum_add(17'd0, data);
  assign acc_nx_s    = csum_add(acc_r, data);
  assign w0_ihl_s    = data[27:24];
  assign w0_bad_s    = (data[31:28] != 4'd4) || (w0_ihl_s < 4'd5) || (32'(w0_ihl_s) > MAX_IHL);
  assign w0_words_s  = data[15:2];
  // On the last plain header word the destination is still on the input bus.
  assign dst_s       = (state_r == HDR) ? data : dest_ip;
  assign hdr_bytes_s = {10'd0, IHL, 2'b00};
  assign plen_s      = total_length - hdr_bytes_s;
  assign pwords_s    = {2'b00, plen_s[15:2]} + {15'd0, |plen_s[1:0]};
  assign chk_bad_s   = (acc_nx_s != 17'h0FFFF);
  assign len_bad_s   = (total_length < hdr_bytes_s);
  assign dm_s        = DEST_FILTER && (dst_s != LOCAL_IP);
  assign enf_s       = dm_s || len_bad_s || (CHECK_CHKSUM && chk_bad_s);
  assign err_v_s     = {1'b0, dm_s, len_bad_s, 1'b0, chk_bad_s};
  // Final header or option word being accepted: time to evaluate the checks.
  assign last_hdr_s  = valid && !start &&
                       (((state_r == HDR) && (idx_r == 3'd4) && (IHL == 4'd5)) ||
                        ((state_r == OPT) && (cnt_r == 16'd1)));

  // Parser state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      idx_r          <= 3'd0;
      cnt_r          <= 16'd0;
      acc_r          <= 17'd0;
      pend_err_r     <= 5'd0;
      pend_ok_r      <= 1'b0;
      version        <= 4'd0;
      IHL            <= 4'd0;
      type_of_ser    <= 8'd0;
      time_to_live   <= 8'd0;
      protocol       <= 8'd0;
      total_length   <= 16'd0;
      identification <= 16'd0;
      head_chks16    <= 16'd0;
      flag           <= 3'd0;
      frag_offset    <= 13'd0;
      src_ip         <= 32'd0;
      dest_ip        <= 32'd0;
      opt_data       <= 32'd0;
      opt_wr         <= 1'b0;
      len_out        <= 16'd0;
      data_out       <= 32'd0;
      wr_en          <= 1'b0;
      keep           <= 4'd0;
      ok             <= 1'b0;
      fin            <= 1'b0;
      err            <= 5'd0;
    end else begin
      opt_wr <= 1'b0;
      wr_en  <= 1'b0;
      fin    <= 1'b0;
      if (valid && start) begin
        // A start inside a datagram closes the old one as aborted.
        if (state_r != IDLE) begin
          fin <= 1'b1;
          ok  <= 1'b0;
          err <= 5'b10000;
        end
        version      <= data[31:28];
        IHL          <= w0_ihl_s;
        type_of_ser  <= data[23:16];
        total_length <= data[15:0];
        acc_r        <= acc_w0_s;
        if (w0_bad_s) begin
          if (w0_words_s <= 14'd1) begin
            state_r <= IDLE;
            fin     <= 1'b1;
            ok      <= 1'b0;
            err     <= {state_r != IDLE, 4'b0010};
          end else begin
            state_r    <= DROP;
            cnt_r      <= {2'b00, w0_words_s} - 16'd1;
            pend_err_r <= 5'b00010;
            pend_ok_r  <= 1'b0;
          end
        end else begin
          state_r <= HDR;
          idx_r   <= 3'd1;
        end
      end else if (valid) begin
        case (state_r)
          HDR: begin
            acc_r <= acc_nx_s;
            idx_r <= idx_r + 3'd1;
            case (idx_r)
              3'd1: begin
                identification <= data[31:16];
                flag           <= data[15:13];
                frag_offset    <= data[12:0];
              end
              3'd2: begin
                time_to_live <= data[31:24];
                protocol     <= data[23:16];
                head_chks16  <= data[15:0];
              end
              3'd3:    src_ip  <= data;
              3'd4:    dest_ip <= data;
              default: idx_r   <= idx_r;
            endcase
            if ((idx_r == 3'd4) && (IHL > 4'd5)) begin
              state_r <= OPT;
              cnt_r   <= {12'd0, IHL - 4'd5};
            end
          end
          OPT: begin
            opt_data <= data;
            opt_wr   <= 1'b1;
            acc_r    <= acc_nx_s;
            cnt_r    <= cnt_r - 16'd1;
          end
          PAYLOAD: begin
            data_out <= data;
            wr_en    <= 1'b1;
            keep     <= (cnt_r == 16'd1) ? last_keep(len_out[1:0]) : 4'b1111;
            cnt_r    <= cnt_r - 16'd1;
            if (cnt_r == 16'd1) begin
              state_r <= IDLE;
              fin     <= 1'b1;
              ok      <= pend_ok_r;
              err     <= pend_err_r;
            end
          end
          DROP: begin
            cnt_r <= cnt_r - 16'd1;
            if (cnt_r == 16'd1) begin
              state_r <= IDLE;
              fin     <= 1'b1;
              ok      <= pend_ok_r;
              err     <= pend_err_r;
            end
          end
          default: state_r <= IDLE;
        endcase
        // Checks close the header; they override the per-state updates above.
        if (last_hdr_s) begin
          len_out    <= plen_s;
          pend_err_r <= err_v_s;
          pend_ok_r  <= !enf_s;
          if (len_bad_s || (pwords_s == 16'd0)) begin
            state_r <= IDLE;
            fin     <= 1'b1;
            ok      <= !enf_s;
            err     <= err_v_s;
          end else begin
            state_r <= enf_s ? DROP : PAYLOAD;
            cnt_r   <= pwords_s;
          end
        end
      end
    end
  end

endmodule

// File: doc/ipv4_rx_parser.md
# ipv4_rx_parser

Parametrised successor to the fixed 20-byte IPv4 header decoder. The block accepts a 32-bit big-endian word stream of one IPv4 datagram and extracts every header field. It verifies the header checksum and the length fields, optionally filters on destination address, and forwards option words and payload words on separate write strobes. It sits between the MAC/Ethernet receive path and the UDP/TCP decoders.

## Interface
Parameters:
- CHECK_CHKSUM, 1: 1 = a bad header checksum drops the payload; 0 = the checksum is computed and reported, never enforced.
- DEST_FILTER, 0: 1 = drop the datagram when dest_ip != LOCAL_IP.
- LOCAL_IP, 32'h980E5E4B: address used by DEST_FILTER.
- MAX_IHL, 15: largest IHL accepted (5..15); larger IHL is an error.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- data  in  32  input word, byte 0 in [31:24].
- valid  in  1  data qualifier; a low cycle stalls the parser.
- start  in  1  marks the first header word; only meaningful when valid=1.
- version, IHL  out  4 each  header fields.
- type_of_ser, time_to_live, protocol  out  8 each.
- total_length, identification, head_chks16  out  16 each; head_chks16 is the checksum field as received.
- flag  out  3; frag_offset  out  13.
- src_ip, dest_ip  out  32 each.
- opt_data  out  32; opt_wr  out  1  option words.
- len_out  out  16  payload byte count = total_length − 4·IHL.
- data_out  out  32; wr_en  out  1; keep  out  4  payload word and byte-valid mask, MSB = byte 0.
- ok  out  1; fin  out  1; err  out  5  {abort, dest_mismatch, len_err, ihl_err, chksum_err}.

## Operation
- States: IDLE, HDR (word index 0..4), OPT, PAYLOAD, DROP.
- Only cycles with valid=1 advance the state or the counters.
- IDLE: valid&start → capture word 0, go to HDR with index=1. Words without start are ignored.
- HDR: each header word is registered into its fields. After word 4:
  - IHL>5 → OPT for IHL−5 words.
  - Otherwise the checks below are evaluated.
- Checksum: a 17-bit accumulator sums 16-bit halves with end-around carry over all header words, options included. chksum_err = (final sum != 16'hFFFF).
- Other checks:
  - ihl_err = IHL<5 or IHL>MAX_IHL, or version != 4.
  - len_err = total_length < 4·IHL.
  - dest_mismatch = DEST_FILTER && dest_ip != LOCAL_IP.
- ihl_err is detected at word 0. The block then enters DROP immediately and discards words until total_length/4 words have been received. If total_length < 4, it discards nothing further.
- OPT: each word → opt_data, opt_wr=1. When the option words are done, the checks are evaluated.
- Branch after checks:
  - Any enforced error (chksum_err only if CHECK_CHKSUM) → DROP, which consumes ceil(len_out/4) words with wr_en=0.
  - Otherwise → PAYLOAD.
- PAYLOAD: each word → data_out with wr_en=1. The word counter runs to ceil(len_out/4). keep=4'b1111, except on the last word: len_out mod 4 = 1/2/3 → 1000/1100/1110.
- len_out=0 → no PAYLOAD/DROP words; fin is issued directly after the last header/option word.
- End of datagram: fin pulses for 1 cycle, coincident with the last wr_en (or the last dropped word). ok = (err has no enforced bit set) and is valid while fin=1. Return to IDLE.
- valid&start in any non-IDLE state:
  - The current datagram is aborted: fin=1, ok=0, err[4]=1 that cycle.
  - The same word is accepted as word 0 of a new datagram.
- Header field outputs hold until overwritten by the next datagram.

## Timing
- Every output is registered. Field, opt_wr, wr_en, data_out and keep appear 1 cycle after the accepted input word.
- err and ok update with fin. chksum_err is never visible before the last header/option word has been accepted.
- Reset: all outputs 0, state IDLE, accumulator and counters 0. Reset mid-datagram discards the datagram with no fin.
- Throughput: 1 word/cycle, no back-pressure. A new start is accepted the cycle after the last word of the previous datagram.

## Test plan
- Good datagram: header 4500001F 12340123 1011D601 9801331B 980E5E4B + "Hello World" (3 words, last 726C6400) → 3 wr_en, keep 1111/1111/1110 on the last, len_out=11, fin & ok=1, err=0.
- Same datagram with checksum field D600 → chksum_err, no wr_en, fin with ok=0. With CHECK_CHKSUM=0 → payload is passed and ok=1.
- IHL=6 with option word 00000000 (checksum adjusted) → one opt_wr before the payload, then payload as above.
- DEST_FILTER=1, dest 980E5E4C → dest_mismatch, payload dropped, fin with ok=0.
- valid toggled low every other cycle during the good datagram → identical output sequence, stretched in time.
- start reasserted during the payload → fin with ok=0 and err[4]=1 that cycle; the next datagram then decodes correctly. total_length=19 → len_err.
